uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Holds the serial FSM state encoding and the default bit period.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational head read; one cycle from push to non-empty.
// A push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive FIFO; byte visible one cycle after the stop-bit sample.
// No backpressure on the line: a byte arriving at a full FIFO is dropped and flagged as overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read_en,
  input  logic       clear_errors,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_error
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_s_q;
  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          frame_error_q;
  logic          armed_q;
  logic          overrun_q, overrun_d;
  logic          fifo_empty, pop_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // armed_q blocks a new start after a framing error until the line has gone idle again (break).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      push_q        <= 1'b0;
      frame_error_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      push_q <= 1'b0;
      if (clear_errors) frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_s_q) armed_q <= 1'b1;
          else if (armed_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else bit_q <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s_q) begin
              push_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
              armed_q       <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (read_en),
    .rdata_o (data_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign pop_ok = read_en && !fifo_empty;

  always_comb begin
    overrun_d = overrun_q;
    if (clear_errors) overrun_d = 1'b0;
    if (push_q && fifo_full && !pop_ok) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun_q <= 1'b0;
    else      overrun_q <= overrun_d;
  end

  assign data_valid  = !fifo_empty;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule
